// File: rtl/latch16_serial_loader_if.sv
// Serial-in / latch-bank-out bundle for latch16_serial_loader.
// master drives the serial stream; slave is the loader itself.
interface latch16_serial_loader_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             ser_in;
    logic             ser_valid;
    logic             busy;
    logic [WIDTH-1:0] latch_data;
    logic             latch_en;
    logic             done;
    logic             err;

    modport master (
        output start, ser_in, ser_valid,
        input  busy, latch_data, latch_en, done, err
    );

    modport slave (
        input  start, ser_in, ser_valid,
        output busy, latch_data, latch_en, done, err
    );
endinterface

// File: rtl/latch16_serial_loader.sv
// Serial-to-parallel feeder for a D-latch bank with a setup/enable/hold load sequence.
// Define PARITY_CHECK_EN to add a trailing even-parity bit per word and the err pulse.
module latch16_serial_loader #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EN_CYCLES = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    latch16_serial_loader_if.slave bus
);
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StShift = 3'd1;
    localparam logic [2:0] StPar   = 3'd2;
    localparam logic [2:0] StSetup = 3'd3;
    localparam logic [2:0] StLoad  = 3'd4;
    localparam logic [2:0] StHold  = 3'd5;

    localparam logic [5:0] LastBit = 6'(WIDTH - 1);
    localparam logic [3:0] LastEn  = 4'(EN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [3:0]       en_cnt_q, en_cnt_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sreg_shift;

    assign sreg_shift = {sreg_q[WIDTH-2:0], bus.ser_in};

`ifndef PARITY_CHECK_EN
    // Without parity the word leaves through sreg_shift, so the MSB is only ever shifted out.
    logic unused_sreg_msb;
    assign unused_sreg_msb = sreg_q[WIDTH-1];
`endif

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        en_cnt_d = en_cnt_q;
        err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end
            end
            StShift: begin
                // A restart takes priority over a bit arriving in the same cycle.
                if (bus.start) begin
                    cnt_d  = '0;
                    sreg_d = '0;
                end else if (bus.ser_valid) begin
                    sreg_d = sreg_shift;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == LastBit) begin
`ifdef PARITY_CHECK_EN
                        state_d = StPar;
`else
                        state_d = StSetup;
                        data_d  = sreg_shift;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            StPar: begin
                if (bus.ser_valid) begin
                    if (^{sreg_q, bus.ser_in} == 1'b0) begin
                        state_d = StSetup;
                        data_d  = sreg_q;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            StSetup: begin
                state_d  = StLoad;
                en_cnt_d = '0;
            end
            StLoad: begin
                if (en_cnt_q == LastEn) begin
                    state_d = StHold;
                end else begin
                    en_cnt_d = en_cnt_q + 4'd1;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they leave flops, not logic.
        en_d   = (state_d == StLoad);
        done_d = (state_d == StHold);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sreg_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            en_cnt_q <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            en_cnt_q <= en_cnt_d;
            en_q     <= en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.latch_data = data_q;
    assign bus.latch_en   = en_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_latch16_serial_loader.sv
// Bench for latch16_serial_loader: two instances (EN_CYCLES 1 and 3) share one serial stream
// and are compared each cycle against a frame-level model, plus fixed-cycle literal checks.
module tb_latch16_serial_loader;
    localparam int W = 16;
`ifdef PARITY_CHECK_EN
    localparam bit Par = 1'b1;
`else
    localparam bit Par = 1'b0;
`endif
    localparam int Off = Par ? 1 : 0;
    localparam int LogN = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, ser_in = 1'b0, ser_valid = 1'b0;
    always #5 clk = ~clk;

    latch16_serial_loader_if #(.WIDTH(W)) bus0 ();
    latch16_serial_loader_if #(.WIDTH(W)) bus1 ();

    latch16_serial_loader #(.WIDTH(W), .EN_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    latch16_serial_loader #(.WIDTH(W), .EN_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.start = start;
    assign bus0.ser_in = ser_in;
    assign bus0.ser_valid = ser_valid;
    assign bus1.start = start;
    assign bus1.ser_in = ser_in;
    assign bus1.ser_valid = ser_valid;

    wire [1:0] busy_v = {bus1.busy, bus0.busy};
    wire [1:0] en_v   = {bus1.latch_en, bus0.latch_en};
    wire [1:0] done_v = {bus1.done, bus0.done};
    wire [1:0] err_v  = {bus1.err, bus0.err};
    logic [15:0] data_v[2];
    assign data_v[0] = bus0.latch_data;
    assign data_v[1] = bus1.latch_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic        en_log[2][LogN];
    logic        done_log[2][LogN];
    logic        err_log[2][LogN];
    logic [15:0] data_log[2][LogN];

    // Frame-level model: phase 0 idle, 1 collecting bits, 2 awaiting parity, 3 post-word timer.
    int          m_phase[2];
    int          m_n[2];
    int          m_k[2];
    logic [15:0] m_word[2];
    logic [15:0] m_data[2];
    bit          m_err[2];
    int          en_cyc[2] = '{1, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_n[i] = 0; m_k[i] = 0;
            m_word[i] = '0; m_data[i] = '0; m_err[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        m_err[i] = 1'b0;
        case (m_phase[i])
            0: if (start) begin m_phase[i] = 1; m_n[i] = 0; m_word[i] = '0; end
            1: begin
                if (start) begin
                    m_n[i] = 0; m_word[i] = '0;
                end else if (ser_valid) begin
                    m_word[i] = {m_word[i][14:0], ser_in};
                    m_n[i]++;
                    if (m_n[i] == W) begin
                        if (Par) m_phase[i] = 2;
                        else begin m_phase[i] = 3; m_k[i] = 0; m_data[i] = m_word[i]; end
                    end
                end
            end
            2: if (ser_valid) begin
                if ((^m_word[i]) == ser_in) begin
                    m_phase[i] = 3; m_k[i] = 0; m_data[i] = m_word[i];
                end else begin
                    m_err[i] = 1'b1; m_phase[i] = 0;
                end
            end
            default: begin
                if (m_k[i] == en_cyc[i] + 1) m_phase[i] = 0;
                else m_k[i]++;
            end
        endcase
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                cyc++;
                for (int i = 0; i < 2; i++) model_step(i);
            end
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic e_en, e_done;
                e_en   = (m_phase[i] == 3) && (m_k[i] >= 1) && (m_k[i] <= en_cyc[i]);
                e_done = (m_phase[i] == 3) && (m_k[i] == en_cyc[i] + 1);
                if (cyc < LogN) begin
                    en_log[i][cyc]   = en_v[i];
                    done_log[i][cyc] = done_v[i];
                    err_log[i][cyc]  = err_v[i];
                    data_log[i][cyc] = data_v[i];
                end
                chk($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(m_phase[i] != 0));
                chk($sformatf("en%0d", i), 32'(en_v[i]), 32'(e_en));
                chk($sformatf("done%0d", i), 32'(done_v[i]), 32'(e_done));
                chk($sformatf("err%0d", i), 32'(err_v[i]), 32'(m_err[i]));
                chk($sformatf("data%0d", i), 32'(data_v[i]), 32'(m_data[i]));
            end
        end
    end

    task automatic tick(input logic s, input logic b, input logic v);
        @(negedge clk);
        start = s; ser_in = b; ser_valid = v;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Start pulse in cycle t0; bits follow MSB first, optionally each preceded by a stall cycle.
    task automatic send(input logic [15:0] w, input bit stall, input logic p, output int t0);
        tick(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        for (int b = 15; b >= 0; b--) begin
            if (stall) tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, w[b], 1'b1);
        end
        if (Par) tick(1'b0, p, 1'b1);
    endtask

    function automatic int count_rise(input int i, input int a, input int b);
        int n = 0;
        for (int c = a; c < b; c++) if (en_log[i][c + 1] && !en_log[i][c]) n++;
        return n;
    endfunction

    initial begin : stim
        int t0, t1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_en", 32'(bus0.latch_en), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        chk("rst_data", 32'(bus0.latch_data), 32'd0);
        #2 rst_n = 1'b1;
        idle(2);

        // Continuous stream of 0xA5C3 (even number of ones: parity bit 0).
        send(16'hA5C3, 1'b0, 1'b0, t0);
        idle(10);
        chk("t2_data_pre", 32'(data_log[0][t0 + 16 + Off]), 32'h0);
        chk("t2_data", 32'(data_log[0][t0 + 17 + Off]), 32'hA5C3);
        chk("t2_en_pre", 32'(en_log[0][t0 + 17 + Off]), 32'd0);
        chk("t2_en", 32'(en_log[0][t0 + 18 + Off]), 32'd1);
        chk("t2_en_post", 32'(en_log[0][t0 + 19 + Off]), 32'd0);
        chk("t2_done", 32'(done_log[0][t0 + 19 + Off]), 32'd1);
        chk("t2_en3_last", 32'(en_log[1][t0 + 20 + Off]), 32'd1);
        chk("t2_en3_post", 32'(en_log[1][t0 + 21 + Off]), 32'd0);
        chk("t2_done3", 32'(done_log[1][t0 + 21 + Off]), 32'd1);

        // Same word, a stall cycle before every bit.
        send(16'hA5C3, 1'b1, 1'b0, t0);
        idle(10);
        chk("t3_en_pre", 32'(en_log[0][t0 + 33 + Off]), 32'd0);
        chk("t3_en", 32'(en_log[0][t0 + 34 + Off]), 32'd1);
        chk("t3_data", 32'(data_log[0][t0 + 33 + Off]), 32'hA5C3);

        // Partial frame, then a restart carrying a bit that must be dropped, then 0x1234.
        tick(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        repeat (7) tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        t1 = cyc;
        for (int b = 15; b >= 0; b--) tick(1'b0, 1'(16'h1234 >> b), 1'b1);
        if (Par) tick(1'b0, 1'b1, 1'b1);
        idle(10);
        chk("t4_data", 32'(data_log[0][t1 + 17 + Off]), 32'h1234);
        chk("t4_en", 32'(en_log[0][t1 + 18 + Off]), 32'd1);
        chk("t4_pulses", 32'(count_rise(0, t0, t1 + 30)), 32'd1);

        // Reset while both instances hold latch_en high.
        send(16'h5A5A, 1'b0, 1'b0, t0);
        idle(2);
        chk("t1_en_before", 32'(bus0.latch_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_en0", 32'(bus0.latch_en), 32'd0);
        chk("t1_en1", 32'(bus1.latch_en), 32'd0);
        chk("t1_data0", 32'(bus0.latch_data), 32'd0);
        chk("t1_data1", 32'(bus1.latch_data), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        chk("t1_busy", 32'(bus0.busy), 32'd0);

        // 0xFFFF into the EN_CYCLES=3 instance.
        send(16'hFFFF, 1'b0, 1'b0, t0);
        idle(10);
        chk("t5_pulses", 32'(count_rise(1, t0, t0 + 30)), 32'd1);
        for (int c = 18; c <= 20; c++) chk("t5_en", 32'(en_log[1][t0 + c + Off]), 32'd1);
        chk("t5_en_post", 32'(en_log[1][t0 + 21 + Off]), 32'd0);
        chk("t5_data_pre", 32'(data_log[1][t0 + 16 + Off]), 32'h0);
        for (int c = 17; c <= 21; c++) chk("t5_data", 32'(data_log[1][t0 + c + Off]), 32'hFFFF);

`ifdef PARITY_CHECK_EN
        // Bad parity: error pulse, no load, previous word kept.
        send(16'h0001, 1'b0, 1'b0, t0);
        idle(10);
        chk("t6_err", 32'(err_log[0][t0 + 18]), 32'd1);
        chk("t6_nopulse", 32'(count_rise(0, t0, t0 + 25)), 32'd0);
        chk("t6_keep", 32'(data_log[0][t0 + 25]), 32'hFFFF);
        // Good parity: loads.
        send(16'h0001, 1'b0, 1'b1, t0);
        idle(10);
        chk("t6_data", 32'(data_log[0][t0 + 18]), 32'h0001);
        chk("t6_en", 32'(en_log[0][t0 + 19]), 32'd1);
        chk("t6_noerr", 32'(err_log[0][t0 + 18]), 32'd0);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
